// File: rtl/oled_refresh_sched.sv
// Refresh scheduler feeding OledCtrl: power-up hold-off, periodic/host
// requests merged into one pending slot, ack timeout and frame statistics.
module oled_refresh_sched #(
    parameter int unsigned STARTUP_CYCLES = 2000,
    parameter int unsigned ACK_TIMEOUT    = 64,
    parameter bit          SKIP_CLEAN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] period,
    input  logic        trigger,
    input  logic        dirty,
    input  logic        busy,
    output logic        refresh,
    output logic        dirty_clr,
    output logic        pending,
    output logic        init_done,
    output logic [15:0] frame_count,
    output logic [7:0]  overrun_count,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        STARTUP,
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t      state;
    logic [31:0] tmr_cnt;
    logic [31:0] su_cnt;
    logic [31:0] ack_cnt;
    logic        tmr_run;
    logic        tick;
    logic        req;
    logic        issue_go;

    assign tmr_run  = enable && (period != 32'd0);
    // >= rather than == so a period lowered below the count ticks at once
    assign tick     = tmr_run && (tmr_cnt >= period - 32'd1);
    assign req      = trigger || (tick && (!SKIP_CLEAN || dirty));
    assign issue_go = (state == IDLE) && pending && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_cnt <= 32'd0;
        end else if (!tmr_run || tick) begin
            tmr_cnt <= 32'd0;
        end else begin
            tmr_cnt <= tmr_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= STARTUP;
            su_cnt        <= 32'd0;
            ack_cnt       <= 32'd0;
            refresh       <= 1'b0;
            dirty_clr     <= 1'b0;
            pending       <= 1'b0;
            init_done     <= 1'b0;
            frame_count   <= 16'd0;
            overrun_count <= 8'd0;
            timeout_err   <= 1'b0;
        end else begin
            refresh   <= 1'b0;
            dirty_clr <= 1'b0;
            // Only a request landing on an already-latched one is an overrun
            pending   <= (pending && !issue_go) || req;
            if (req && pending && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end
            unique case (state)
                STARTUP: begin
                    if (su_cnt == STARTUP_CYCLES - 1) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        su_cnt <= su_cnt + 32'd1;
                    end
                end
                IDLE: begin
                    if (issue_go) begin
                        refresh   <= 1'b1;
                        dirty_clr <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ack_cnt <= 32'd0;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == ACK_TIMEOUT - 1) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 32'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        frame_count <= frame_count + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= STARTUP;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_refresh_sched.sv
// Directed bench for oled_refresh_sched with a simple OledCtrl busy model.
module tb_oled_refresh_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] period = 32'd0;
    logic        trigger = 1'b0;
    logic        dirty = 1'b0;
    logic        busy;
    logic        refresh;
    logic        dirty_clr;
    logic        pending;
    logic        init_done;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;
    logic        timeout_err;

    oled_refresh_sched #(
        .STARTUP_CYCLES(2000),
        .ACK_TIMEOUT   (64),
        .SKIP_CLEAN    (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .period       (period),
        .trigger      (trigger),
        .dirty        (dirty),
        .busy         (busy),
        .refresh      (refresh),
        .dirty_clr    (dirty_clr),
        .pending      (pending),
        .init_done    (init_done),
        .frame_count  (frame_count),
        .overrun_count(overrun_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bmode 0: busy low, 1: busy high 20 cycles after each refresh, 2: busy high
    int bmode = 0;
    int bcnt = 0;
    always @(negedge clk) begin
        if (bmode == 1) begin
            if (refresh) bcnt <= 22;
            else if (bcnt != 0) bcnt <= bcnt - 1;
        end else begin
            bcnt <= 0;
        end
    end
    assign busy = (bmode == 2) || (bmode == 1 && bcnt != 0 && bcnt <= 20);

    int ref_cnt = 0;
    int last_ref = 0;
    int prev_ref = 0;
    int dc_bad = 0;
    int early_ref = 0;
    always @(negedge clk) begin
        if (refresh) begin
            ref_cnt  <= ref_cnt + 1;
            prev_ref <= last_ref;
            last_ref <= cyc;
            if (!init_done) early_ref <= early_ref + 1;
        end
        if (refresh !== dirty_clr) dc_bad <= dc_bad + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_trigger();
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
    endtask

    task automatic wait_refresh(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (refresh) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_init(input int t0);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (init_done) begin
                found = 1'b1;
                break;
            end
        end
        expect_eq("init_seen", found, 1);
        expect_eq("init_cycle", cyc - t0, 2000);
    endtask

    int t0, base_ref, base_ov, tm;
    bit found;

    initial begin
        bmode = 1;
        repeat (3) @(negedge clk);
        expect_eq("reset_outs", {refresh, dirty_clr, pending, init_done,
                  frame_count, overrun_count, timeout_err}, 0);

        // startup hold-off with an early trigger
        rst = 1'b0;
        t0  = cyc;
        repeat (9) @(negedge clk);
        trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        expect_eq("pend_startup", pending, 1);
        wait_init(t0);
        expect_eq("early_ref", early_ref, 0);
        @(negedge clk);
        expect_eq("first_ref", refresh, 1);
        expect_eq("first_dclr", dirty_clr, 1);
        expect_eq("pend_clr", pending, 0);
        @(negedge clk);
        expect_eq("ref_1cyc", refresh, 0);
        repeat (40) @(negedge clk);
        expect_eq("frames_t1", frame_count, 1);

        // periodic timer, content always dirty
        dirty    = 1'b1;
        period   = 32'd100;
        base_ref = ref_cnt;
        @(negedge clk) enable = 1'b1;
        repeat (505) @(negedge clk);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        expect_eq("per_refs", ref_cnt - base_ref, 5);
        expect_eq("per_space", last_ref - prev_ref, 100);
        expect_eq("frames_t2", frame_count, 6);
        expect_eq("ovr_t2", overrun_count, 0);

        // clean frames skipped until dirty rises
        dirty    = 1'b0;
        base_ref = ref_cnt;
        @(negedge clk) enable = 1'b1;
        tm = cyc;
        repeat (300) @(negedge clk);
        expect_eq("clean_skip", ref_cnt - base_ref, 0);
        dirty = 1'b1;
        wait_refresh(150, found);
        expect_eq("dirty_ref", found, 1);
        expect_eq("dirty_when", cyc - tm, 401);
        expect_eq("dirty_dclr", dirty_clr, 1);
        enable = 1'b0;
        dirty  = 1'b0;
        repeat (40) @(negedge clk);
        expect_eq("frames_t3", frame_count, 7);

        // merging while controller self-busy
        bmode = 2;
        repeat (5) @(negedge clk);
        base_ov  = overrun_count;
        base_ref = ref_cnt;
        for (int i = 0; i < 4; i++) begin
            pulse_trigger();
            repeat (100) @(negedge clk);
        end
        expect_eq("ovr_merge", overrun_count - base_ov, 3);
        expect_eq("pend_held", pending, 1);
        expect_eq("busy_noref", ref_cnt - base_ref, 0);
        bmode = 1;
        repeat (80) @(negedge clk);
        expect_eq("one_ref", ref_cnt - base_ref, 1);
        expect_eq("frames_t4", frame_count, 8);

        // ack timeout with busy stuck low
        bmode = 0;
        pulse_trigger();
        wait_refresh(10, found);
        expect_eq("to_ref", found, 1);
        repeat (64) @(negedge clk);
        expect_eq("to_early", timeout_err, 0);
        @(negedge clk);
        expect_eq("to_set", timeout_err, 1);
        expect_eq("to_frames", frame_count, 8);
        bmode = 1;
        pulse_trigger();
        wait_refresh(10, found);
        expect_eq("after_to_ref", found, 1);
        repeat (40) @(negedge clk);
        expect_eq("frames_t5", frame_count, 9);
        expect_eq("to_sticky", timeout_err, 1);

        // async reset in WAIT_DONE
        pulse_trigger();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                found = 1'b1;
                break;
            end
        end
        expect_eq("busy_seen", found, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expect_eq("async_rst", {refresh, dirty_clr, pending, init_done,
                  frame_count, overrun_count, timeout_err}, 0);
        @(negedge clk) rst = 1'b0;
        t0 = cyc;
        wait_init(t0);
        expect_eq("frames_rst", frame_count, 0);

        expect_eq("dclr_align", dc_bad, 0);
        expect_eq("early_ref2", early_ref, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
